// File: rtl/sync_fifo_pkg.sv
// Shared widths, reset values and flag-vector layout for sync_fifo_ctrl and fifo_mem.
package sync_fifo_pkg;

    function automatic int addr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // The count needs one bit more than the pointers so that DEPTH itself is representable
    function automatic int cnt_w(input int depth);
        return addr_w(depth) + 1;
    endfunction

    localparam logic RST_VLD = 1'b0;
    localparam logic RST_ERR = 1'b0;
    localparam logic RST_SEL = 1'b0;

    localparam int FLG_FULL   = 0;
    localparam int FLG_EMPTY  = 1;
    localparam int FLG_AFULL  = 2;
    localparam int FLG_AEMPTY = 3;
    localparam int FLG_W      = 4;

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port RAM, DATA_W x DEPTH, synchronous write and registered synchronous read.
module fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    localparam int ADDR_W = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // Storage is intentionally not reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read-before-write when both ports hit the same address
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO: pointers, occupancy count, threshold flags, error pulses and output stage.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through; default is a 1-cycle registered read.
module sync_fifo_ctrl
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AF_LVL = DEPTH - 2,
    parameter int AE_LVL = 2,
    localparam int ADDR_W = addr_w(DEPTH),
    localparam int CNT_W  = cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              re,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              underflow
);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("sync_fifo_ctrl: DEPTH must be a power of two >= 2");
        end
        if (AF_LVL < 1 || AF_LVL > DEPTH) begin : g_bad_af
            $error("sync_fifo_ctrl: AF_LVL must lie in 1..DEPTH");
        end
        if (AE_LVL < 0 || AE_LVL > DEPTH - 1) begin : g_bad_ae
            $error("sync_fifo_ctrl: AE_LVL must lie in 0..DEPTH-1");
        end
    endgenerate

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              vld_q, vld_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic              rd_acc, wr_acc;
    logic              mem_we, mem_re;
    logic [DATA_W-1:0] mem_rdata;
    logic [FLG_W-1:0]  flags;

    always_comb begin
        flags             = '0;
        flags[FLG_FULL]   = (count_q == CNT_W'(DEPTH));
`ifdef SYNC_FIFO_FWFT_EN
        flags[FLG_EMPTY]  = !vld_q;
`else
        flags[FLG_EMPTY]  = (count_q == '0);
`endif
        flags[FLG_AFULL]  = (count_q >= CNT_W'(AF_LVL));
        flags[FLG_AEMPTY] = (count_q <= CNT_W'(AE_LVL));
    end

`ifdef SYNC_FIFO_FWFT_EN
    logic              sel_q, sel_d;
    logic [DATA_W-1:0] byp_q;
    logic              ram_empty, load, byp_load;

    // The output stage holds the head word; the RAM holds everything behind it
    always_comb begin
        rd_acc    = re && vld_q;
        wr_acc    = we && (!flags[FLG_FULL] || rd_acc);
        ram_empty = (count_q == CNT_W'(vld_q));
        load      = !vld_q || rd_acc;
        mem_re    = load && !ram_empty;
        byp_load  = wr_acc && load && ram_empty;
        mem_we    = wr_acc && !byp_load;
        vld_d     = load ? (mem_re || byp_load) : vld_q;
        sel_d     = sel_q;
        if (byp_load) begin
            sel_d = 1'b1;
        end else if (mem_re) begin
            sel_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q <= RST_SEL;
            byp_q <= '0;
        end else begin
            sel_q <= sel_d;
            if (byp_load) begin
                byp_q <= wr_data;
            end
        end
    end

    assign rd_data = sel_q ? byp_q : mem_rdata;
`else
    always_comb begin
        rd_acc = re && !flags[FLG_EMPTY];
        wr_acc = we && (!flags[FLG_FULL] || rd_acc);
        mem_re = rd_acc;
        mem_we = wr_acc;
        vld_d  = rd_acc;
    end

    assign rd_data = mem_rdata;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = we && !wr_acc;
        unf_d    = re && !rd_acc;
        if (mem_we) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (mem_re) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        if (wr_acc && !rd_acc) begin
            count_d = count_q + CNT_W'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= RST_VLD;
            ovf_q    <= RST_ERR;
            unf_q    <= RST_ERR;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            vld_q    <= vld_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (mem_we),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_data),
        .rd_en   (mem_re),
        .rd_addr (rd_ptr_q),
        .rd_data (mem_rdata)
    );

    assign rd_valid     = vld_q;
    assign full         = flags[FLG_FULL];
    assign empty        = flags[FLG_EMPTY];
    assign almost_full  = flags[FLG_AFULL];
    assign almost_empty = flags[FLG_AEMPTY];
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
- Parametrised single-clock FIFO: storage, read/write pointers and control integrated in one block.
- Generalises the fixed-depth FIFO controller:
  - configurable data width and depth;
  - registered occupancy count;
  - programmable almost-full/almost-empty thresholds;
  - overflow/underflow error pulses.
- Sits between a producer and a consumer in the same clock domain. Downstream uses it as the standard buffering primitive.

Parameters:
- DATA_W, 8, data word width in bits.
- DEPTH, 16, number of entries; power of two, >= 2.
- AF_LVL, DEPTH-2, almost_full asserts when count >= AF_LVL.
- AE_LVL, 2, almost_empty asserts when count <= AE_LVL.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- we  in  1  write request.
- wr_data  in  DATA_W  write data, sampled with we.
- re  in  1  read request.
- rd_data  out  DATA_W  read data.
- rd_valid  out  1  rd_data holds a popped word this cycle.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LVL.
- almost_empty  out  1  count <= AE_LVL.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  one-cycle pulse: a write was rejected.
- underflow  out  1  one-cycle pulse: a read was rejected.

Behaviour:
- Reset (rst=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0, rd_data=0;
  - rd_valid=0, full=0, empty=1, almost_full=0, almost_empty=1, overflow=0, underflow=0.
  - Reset mid-operation discards all contents. The memory array is not cleared.
- Pointers: ADDR_W=$clog2(DEPTH) bits. Each wraps DEPTH-1 -> 0 on its own accept.
- Accept rules, evaluated on the same edge:
  - rd_acc = re && !empty.
  - wr_acc = we && (!full || rd_acc).
  - So a write to a full FIFO succeeds when a read is accepted in the same cycle.
- count update: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither. It never leaves 0..DEPTH.
- Flags:
  - full, empty, almost_full and almost_empty are decoded combinationally from the count register.
  - They therefore change in the cycle after the accepting edge.
- Read latency (default mode):
  - on rd_acc, rd_data <= mem[rd_ptr] and rd_valid=1 in the next cycle;
  - otherwise rd_valid=0 and rd_data holds its last value.
- Simultaneous we and re on an empty FIFO:
  - the write is accepted;
  - the read is rejected and underflow pulses.
  - The read does not see the word written in that cycle; there is no bypass.
- Error pulses: overflow=1 for one cycle after an edge where we && !wr_acc; underflow likewise for re && !rd_acc. Both are registered.
- Parameter rules: AF_LVL must lie in 1..DEPTH and AE_LVL in 0..DEPTH-1. Illegal values fail elaboration through a generate-time check.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - the head word is presented on rd_data whenever rd_valid=1;
  - re while rd_valid=1 pops it, and the next word (if any) appears the following cycle;
  - a write into an empty FIFO gives rd_valid=1 one cycle after the write edge, loaded directly from wr_data;
  - count includes the word held in the output stage;
  - empty = !rd_valid;
  - underflow = re && !rd_valid.
- Not defined: the 1-cycle registered-read behaviour above.

Decomposition:
- Package sync_fifo_pkg holds:
  - the ADDR_W/CNT_W width-calculation function;
  - the reset constants;
  - the localparams for the flag encoding.
- One sub-module, fifo_mem: simple dual-port RAM, DATA_W x DEPTH, synchronous write and synchronous read. The top level holds the pointers, count, flags and output stage.

Test Plan (DEPTH=4, DATA_W=8, AF_LVL=3, AE_LVL=1):
- Reset, then write 0x11,0x22,0x33,0x44 on consecutive cycles -> count 1,2,3,4; almost_full rises after 0x33; full=1 after 0x44; almost_empty clears after 0x22.
- Full, then write 0x55 alone -> overflow pulses for 1 cycle; count stays 4; contents unchanged.
- Full, then we=re=1 with wr_data=0x55 -> rd_data=0x11 with rd_valid the next cycle; count stays 4; later reads return 0x22,0x33,0x44,0x55.
- Empty, then we=re=1 with 0xA5 -> underflow pulses; count=1; the next read returns 0xA5.
- Write 6 words and read 6, interleaved to cross the pointer wrap -> data in order; empty=1 at the end; no error pulses.
- Drop rst low while count=3 -> all outputs at reset values immediately; after rst rises a read gives underflow.
- SYNC_FIFO_FWFT_EN: write 0x3C into an empty FIFO -> rd_valid=1 and rd_data=0x3C the next cycle with no re; re pops it and rd_valid drops.
